// File: rtl/ddr2_pkg.sv
// rtl/ddr2_pkg.sv - command encodings, FSM states and default timing for the DDR2 command issuer
`ifndef DRAM_BA_WIDTH
`define DRAM_BA_WIDTH 3
`endif
`ifndef DRAM_ADDR_WIDTH
`define DRAM_ADDR_WIDTH 14
`endif

package ddr2_pkg;

    // {cs_n, ras_n, cas_n, we_n}
    typedef enum logic [3:0] {
        CMD_NOP = 4'b0111,
        CMD_ACT = 4'b0011,
        CMD_RD  = 4'b0101,
        CMD_WR  = 4'b0100,
        CMD_PRE = 4'b0010,
        CMD_REF = 4'b0001
    } cmd_e;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ACT,
        S_WAIT_RCD,
        S_RW,
        S_WAIT_PRE,
        S_PRE,
        S_WAIT_RP,
        S_REF,
        S_WAIT_RFC
    } state_e;

    localparam int DEF_T_RCD    = 3;
    localparam int DEF_T_RAS    = 8;
    localparam int DEF_T_RW2PRE = 4;
    localparam int DEF_T_RP     = 3;
    localparam int DEF_T_RFC    = 20;
    localparam int DEF_T_REFI   = 780;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ddr2_ref_timer.sv
// rtl/ddr2_ref_timer.sv - free-running refresh interval counter with a sticky pending flag
module ddr2_ref_timer
    import ddr2_pkg::*;
#(
    parameter int T_REFI = DEF_T_REFI,
    parameter int CNT_W  = $clog2(T_REFI + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ref_clr,
    output logic ref_pending
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;

    always_comb begin
        cnt_d  = cnt_q - CNT_W'(1);
        pend_d = pend_q;
        if (ref_clr) begin
            pend_d = 1'b0;
        end
        // A fresh expiry wins over a same-cycle clear so no interval is lost.
        if (cnt_q == '0) begin
            cnt_d  = CNT_W'(T_REFI - 1);
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= CNT_W'(T_REFI - 1);
            pend_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
        end
    end

    assign ref_pending = pend_q;

endmodule

// File: rtl/ddr2_cmd_issuer.sv
// rtl/ddr2_cmd_issuer.sv - close-page DDR2 command sequencer: ACT, RD/WR, PRE with periodic REF
module ddr2_cmd_issuer
    import ddr2_pkg::*;
#(
    parameter int T_RCD    = DEF_T_RCD,
    parameter int T_RAS    = DEF_T_RAS,
    parameter int T_RW2PRE = DEF_T_RW2PRE,
    parameter int T_RP     = DEF_T_RP,
    parameter int T_RFC    = DEF_T_RFC,
    parameter int T_REFI   = DEF_T_REFI
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_write,
    input  logic [`DRAM_BA_WIDTH-1:0]   req_ba,
    input  logic [`DRAM_ADDR_WIDTH-1:0] req_row,
    input  logic [9:0]                  req_col,
    output logic                        cke,
    output logic                        cs_n,
    output logic                        ras_n,
    output logic                        cas_n,
    output logic                        we_n,
    output logic [`DRAM_BA_WIDTH-1:0]   ba,
    output logic [`DRAM_ADDR_WIDTH-1:0] addr,
    output logic                        rd_start,
    output logic                        wr_start
);

    localparam int BA_W = `DRAM_BA_WIDTH;
    localparam int AW   = `DRAM_ADDR_WIDTH;

    // Cycles from one issued command to the next step; the idle gaps end one
    // cycle early because the IDLE handshake cycle itself precedes the command.
    localparam int GAP_RCD = T_RCD;
    localparam int GAP_PRE = max2(T_RAS - T_RCD, T_RW2PRE);
    localparam int GAP_RP  = max2(T_RP - 1, 1);
    localparam int GAP_RFC = max2(T_RFC - 1, 1);
    localparam int MAX_T   = max2(max2(max2(T_RCD, T_RAS), max2(T_RW2PRE, T_RP)),
                                  max2(T_RFC, T_REFI));
    localparam int CNT_W   = $clog2(MAX_T + 1);

    if (T_RCD < 1 || T_RAS < 1 || T_RW2PRE < 1 || T_RP < 1 || T_RFC < 1 || T_REFI < 1
        || AW < 11) begin : g_bad_param
        $error("ddr2_cmd_issuer: timing parameters must be >= 1 and address width >= 11");
    end

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              cke_q, cke_d;
    logic [3:0]        cmd_q, cmd_d;
    logic [BA_W-1:0]   ba_q, ba_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic              rd_start_q, rd_start_d;
    logic              wr_start_q, wr_start_d;
    logic              cap_write_q, cap_write_d;
    logic [BA_W-1:0]   cap_ba_q, cap_ba_d;
    logic [9:0]        cap_col_q, cap_col_d;
    logic              ref_pending;
    logic              ref_clr;

    ddr2_ref_timer #(
        .T_REFI (T_REFI),
        .CNT_W  (CNT_W)
    ) u_ref_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .ref_clr     (ref_clr),
        .ref_pending (ref_pending)
    );

    assign req_ready = (state_q == S_IDLE) && cke_q && !ref_pending;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cke_d       = 1'b1;
        cap_write_d = cap_write_q;
        cap_ba_d    = cap_ba_q;
        cap_col_d   = cap_col_q;
        ref_clr     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cke_q && ref_pending) begin
                    state_d = S_REF;
                    ref_clr = 1'b1;
                end else if (req_valid && req_ready) begin
                    state_d     = S_ACT;
                    cap_write_d = req_write;
                    cap_ba_d    = req_ba;
                    cap_col_d   = req_col;
                end
            end
            S_ACT: begin
                if (GAP_RCD == 1) begin
                    state_d = S_RW;
                end else begin
                    state_d = S_WAIT_RCD;
                    cnt_d   = CNT_W'(GAP_RCD - 2);
                end
            end
            S_WAIT_RCD: begin
                if (cnt_q == '0) state_d = S_RW;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            S_RW: begin
                if (GAP_PRE == 1) begin
                    state_d = S_PRE;
                end else begin
                    state_d = S_WAIT_PRE;
                    cnt_d   = CNT_W'(GAP_PRE - 2);
                end
            end
            S_WAIT_PRE: begin
                if (cnt_q == '0) state_d = S_PRE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            S_PRE: begin
                if (GAP_RP == 1) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT_RP;
                    cnt_d   = CNT_W'(GAP_RP - 2);
                end
            end
            S_WAIT_RP: begin
                if (cnt_q == '0) state_d = S_IDLE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            S_REF: begin
                if (GAP_RFC == 1) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT_RFC;
                    cnt_d   = CNT_W'(GAP_RFC - 2);
                end
            end
            S_WAIT_RFC: begin
                if (cnt_q == '0) state_d = S_IDLE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    // The bus register is loaded from the state being entered, so each command
    // appears in exactly the cycle its state is occupied.
    always_comb begin
        cmd_d      = CMD_NOP;
        ba_d       = '0;
        addr_d     = '0;
        rd_start_d = 1'b0;
        wr_start_d = 1'b0;
        case (state_d)
            S_ACT: begin
                cmd_d  = CMD_ACT;
                ba_d   = req_ba;
                addr_d = req_row;
            end
            S_RW: begin
                cmd_d        = cap_write_d ? CMD_WR : CMD_RD;
                ba_d         = cap_ba_d;
                addr_d[9:0]  = cap_col_d;
                rd_start_d   = !cap_write_d;
                wr_start_d   = cap_write_d;
            end
            S_PRE: begin
                cmd_d      = CMD_PRE;
                ba_d       = cap_ba_d;
                addr_d[10] = 1'b1;
            end
            S_REF: begin
                cmd_d = CMD_REF;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            cke_q       <= 1'b0;
            cmd_q       <= 4'hF;
            ba_q        <= '0;
            addr_q      <= '0;
            rd_start_q  <= 1'b0;
            wr_start_q  <= 1'b0;
            cap_write_q <= 1'b0;
            cap_ba_q    <= '0;
            cap_col_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cke_q       <= cke_d;
            cmd_q       <= cmd_d;
            ba_q        <= ba_d;
            addr_q      <= addr_d;
            rd_start_q  <= rd_start_d;
            wr_start_q  <= wr_start_d;
            cap_write_q <= cap_write_d;
            cap_ba_q    <= cap_ba_d;
            cap_col_q   <= cap_col_d;
        end
    end

    assign cke                       = cke_q;
    assign {cs_n, ras_n, cas_n, we_n} = cmd_q;
    assign ba                        = ba_q;
    assign addr                      = addr_q;
    assign rd_start                  = rd_start_q;
    assign wr_start                  = wr_start_q;

endmodule

// File: tb/tb_ddr2_cmd_issuer.sv
// tb/tb_ddr2_cmd_issuer.sv - random-traffic bench against a timestamp-based DDR2 schedule model
`ifndef DRAM_BA_WIDTH
`define DRAM_BA_WIDTH 3
`endif
`ifndef DRAM_ADDR_WIDTH
`define DRAM_ADDR_WIDTH 14
`endif

module tb_ddr2_cmd_issuer;

    localparam int BA_W     = `DRAM_BA_WIDTH;
    localparam int AW       = `DRAM_ADDR_WIDTH;
    localparam int T_RCD    = 3;
    localparam int T_RAS    = 8;
    localparam int T_RW2PRE = 4;
    localparam int T_RP     = 3;
    localparam int T_RFC    = 20;
    localparam int T_REFI   = 100;

    localparam logic [3:0] E_NOP = 4'b0111;
    localparam logic [3:0] E_ACT = 4'b0011;
    localparam logic [3:0] E_RD  = 4'b0101;
    localparam logic [3:0] E_WR  = 4'b0100;
    localparam logic [3:0] E_PRE = 4'b0010;
    localparam logic [3:0] E_REF = 4'b0001;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic            req_write = 1'b0;
    logic [BA_W-1:0] req_ba = '0;
    logic [AW-1:0]   req_row = '0;
    logic [9:0]      req_col = '0;
    logic            cke, cs_n, ras_n, cas_n, we_n;
    logic [BA_W-1:0] ba;
    logic [AW-1:0]   addr;
    logic            rd_start, wr_start;
    logic [3:0]      cmd_bus;

    assign cmd_bus = {cs_n, ras_n, cas_n, we_n};

    always #5 clk = ~clk;

    ddr2_cmd_issuer #(
        .T_RCD(T_RCD), .T_RAS(T_RAS), .T_RW2PRE(T_RW2PRE),
        .T_RP(T_RP), .T_RFC(T_RFC), .T_REFI(T_REFI)
    ) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_ba(req_ba), .req_row(req_row), .req_col(req_col),
        .cke(cke), .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n),
        .ba(ba), .addr(addr), .rd_start(rd_start), .wr_start(wr_start)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Expected schedule: absolute cycle -> command and address fields.
    logic [3:0]      exp_cmd  [int];
    logic [BA_W-1:0] exp_ba   [int];
    logic [AW-1:0]   exp_addr [int];
    int  cyc;
    int  next_ok;
    int  last_ref;
    int  last_exp;
    bit  have_exp;
    bit  have_req;

    task automatic sched(input int c, input logic [3:0] cmd, input logic [BA_W-1:0] b,
                         input logic [AW-1:0] a);
        exp_cmd[c]  = cmd;
        exp_ba[c]   = b;
        exp_addr[c] = a;
    endtask

    task automatic model_reset();
        exp_cmd.delete();
        exp_ba.delete();
        exp_addr.delete();
        cyc      = 0;
        next_ok  = 0;
        last_ref = -1;
        last_exp = -1;
        have_exp = 1'b0;
    endtask

    task automatic model_step(input int c);
        bit pend, idle, rdy;
        int a, p;
        logic [3:0] e;
        if ((c + 1) % T_REFI == 0) begin
            last_exp = c;
            have_exp = 1'b1;
        end
        pend = have_exp && (last_exp >= last_ref);
        idle = (c >= next_ok - 1);
        rdy  = idle && !pend;
        check($sformatf("ready@%0d", c), 32'(req_ready), 32'(rdy));
        check($sformatf("cke@%0d", c), 32'(cke), 32'(1'b1));
        if (exp_cmd.exists(c)) begin
            e = exp_cmd[c];
            check($sformatf("cmd@%0d", c), 32'(cmd_bus), 32'(e));
            if (e == E_ACT || e == E_RD || e == E_WR) begin
                check($sformatf("ba@%0d", c), 32'(ba), 32'(exp_ba[c]));
                check($sformatf("addr@%0d", c), 32'(addr), 32'(exp_addr[c]));
            end else if (e == E_PRE) begin
                check($sformatf("pre_a10@%0d", c), 32'(addr[10]), 32'(1'b1));
            end
            check($sformatf("rd_start@%0d", c), 32'(rd_start), 32'(e == E_RD));
            check($sformatf("wr_start@%0d", c), 32'(wr_start), 32'(e == E_WR));
        end else begin
            check($sformatf("nop@%0d", c), 32'(cmd_bus), 32'(E_NOP));
            check($sformatf("rd_start@%0d", c), 32'(rd_start), 32'(1'b0));
            check($sformatf("wr_start@%0d", c), 32'(wr_start), 32'(1'b0));
        end
        if (idle && pend) begin
            sched(c + 1, E_REF, '0, '0);
            last_ref = c + 1;
            next_ok  = c + 1 + T_RFC;
        end else if (rdy && req_valid) begin
            a = c + 1;
            p = a + ((T_RAS > T_RCD + T_RW2PRE) ? T_RAS : T_RCD + T_RW2PRE);
            sched(a, E_ACT, req_ba, req_row);
            sched(a + T_RCD, req_write ? E_WR : E_RD, req_ba, AW'(req_col));
            sched(p, E_PRE, req_ba, AW'(1 << 10));
            next_ok  = p + T_RP;
            have_req = 1'b0;
        end
    endtask

    task automatic step(input int prob);
        @(posedge clk);
        #1;
        if (!have_req) begin
            req_write = 1'($urandom);
            req_ba    = BA_W'($urandom);
            req_row   = AW'($urandom);
            req_col   = 10'($urandom);
            if (prob > 0 && int'($urandom_range(99)) < prob) have_req = 1'b1;
        end
        req_valid = have_req;
        @(negedge clk);
        model_step(cyc);
        cyc++;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_cke"}, 32'(cke), 32'(1'b0));
        check({tag, "_bus"}, 32'(cmd_bus), 32'(4'hF));
        check({tag, "_ba"}, 32'(ba), 32'(0));
        check({tag, "_addr"}, 32'(addr), 32'(0));
        check({tag, "_rd"}, 32'(rd_start), 32'(1'b0));
        check({tag, "_wr"}, 32'(wr_start), 32'(1'b0));
        check({tag, "_ready"}, 32'(req_ready), 32'(1'b0));
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = 1'b0;
        have_req  = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_reset_vals("rst");
        end
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        have_req = 1'b0;
        model_reset();
        do_reset();

        // Directed read: handshake at cycle 10 with fixed expectations.
        for (int i = 0; i < 25; i++) begin
            if (cyc == 10) begin
                have_req  = 1'b1;
                req_write = 1'b0;
                req_ba    = BA_W'(2);
                req_row   = AW'('h1A5);
                req_col   = 10'h03C;
            end
            step(0);
            case (cyc - 1)
                11: begin
                    check("d_act_cmd", 32'(cmd_bus), 32'(4'b0011));
                    check("d_act_ba", 32'(ba), 32'(2));
                    check("d_act_row", 32'(addr), 32'h1A5);
                end
                14: begin
                    check("d_rd_cmd", 32'(cmd_bus), 32'(4'b0101));
                    check("d_rd_col", 32'(addr), 32'h03C);
                    check("d_rd_start", 32'(rd_start), 32'(1'b1));
                end
                19: begin
                    check("d_pre_cmd", 32'(cmd_bus), 32'(4'b0010));
                    check("d_pre_a10", 32'(addr[10]), 32'(1'b1));
                end
                22: check("d_ready", 32'(req_ready), 32'(1'b1));
                default: ;
            endcase
        end

        // Back-to-back, mixed, then quiet traffic with refresh interleaving.
        repeat (300) step(100);
        repeat (600) step(30);
        repeat (350) step(0);

        // Reset while waiting for tRCD: the captured request must never issue.
        do_reset();
        repeat (5) step(0);
        have_req  = 1'b1;
        req_write = 1'b1;
        req_ba    = BA_W'(5);
        req_row   = AW'('h2222);
        req_col   = 10'h155;
        step(0);
        step(0);
        @(posedge clk);
        #2;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        have_req  = 1'b0;
        #1;
        check_reset_vals("midrst");
        do_reset();
        repeat (150) step(0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
